fetch_pc_unit: RTL

//  Instruction-fetch stage: owns the PC register and issues one instruction-memory request at a time.

---
 rtl/fetch_pc_unit_pkg.sv | 18 +
 rtl/fetch_pc_unit_if.sv | 31 +++
 rtl/fetch_skid_buf.sv | 60 ++++++
 rtl/fetch_pc_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   Default widths and constants for the PC register and IF/ID entry.
//   FSM state encoding used by fetch_pc_unit.
package fetch_pc_unit_pkg;

    localparam int unsigned    DefaultDataW    = 16;
    localparam logic [15:0]    DefaultResetPc  = 16'h0000;
    localparam int unsigned    DefaultPcStep   = 2;
    localparam logic [15:0]    DefaultNopInstr = 16'h0000;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/response bus.
//   imem_req    fetch request valid            (master -> slave)
//   imem_addr   fetch address                  (master -> slave)
//   imem_gnt    request accepted this cycle    (slave -> master)
//   imem_rvalid read data valid                (slave -> master)
//   imem_rdata  instruction word               (slave -> master)
interface fetch_pc_unit_if #(
    parameter int unsigned DATA_W = 16
);
    logic              imem_req;
    logic [DATA_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding buffer for a response that ID could not accept.
//   clk      clock
//   rst_n    asynchronous active-low reset
//   load_i   capture pc_i/instr_i, mark full
//   drain_i  entry consumed, mark empty
//   clear_i  flush (wins over load/drain)
//   valid_o  buffer holds an entry
//   pc_o     buffered PC
//   instr_o  buffered instruction
module fetch_skid_buf #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] instr_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] instr_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC register, single-outstanding imem fetch FSM, IF/ID register.
//   clk, rst_n   clock, asynchronous active-low reset
//   npc_in       next PC from the external 2:1 mux (pc_plus or branch target)
//   redirect     branch taken: flush IF/ID and load npc_in immediately
//   stall        ID cannot accept a new IF/ID entry
//   imem         instruction-memory bus (master side)
//   pc_q         current PC
//   pc_plus      pc_q + PC_STEP, wraps modulo 2^DATA_W
//   if_id_*      IF/ID pipeline register
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int unsigned       DATA_W    = DefaultDataW,
    parameter logic [DATA_W-1:0] RESET_PC  = DefaultResetPc,
    parameter int unsigned       PC_STEP   = DefaultPcStep,
    parameter logic [DATA_W-1:0] NOP_INSTR = DefaultNopInstr
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   npc_in,
    input  logic                redirect,
    input  logic                stall,
    fetch_pc_unit_if.master     imem,
    output logic [DATA_W-1:0]   pc_q,
    output logic [DATA_W-1:0]   pc_plus,
    output logic                if_id_valid,
    output logic [DATA_W-1:0]   if_id_pc,
    output logic [DATA_W-1:0]   if_id_instr
);

    fetch_state_e      state_q, state_d;
    logic              kill_q, kill_d;
    logic [DATA_W-1:0] pc_d;
    logic              if_id_valid_d;
    logic [DATA_W-1:0] if_id_pc_d, if_id_instr_d;

    logic              acc;
    logic              skid_load, skid_drain, skid_clear;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_pc, skid_instr;

    assign pc_plus        = pc_q + DATA_W'(PC_STEP);
    assign acc            = !stall || !if_id_valid;
    assign imem.imem_req  = (state_q == S_REQ);
    assign imem.imem_addr = pc_q;

    fetch_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (skid_clear),
        .pc_i    (pc_q),
        .instr_i (imem.imem_rdata),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    always_comb begin
        state_d       = state_q;
        kill_d        = kill_q;
        pc_d          = pc_q;
        if_id_valid_d = if_id_valid;
        if_id_pc_d    = if_id_pc;
        if_id_instr_d = if_id_instr;
        skid_load     = 1'b0;
        skid_drain    = 1'b0;
        skid_clear    = 1'b0;

        // ID consumed the entry; a load below may refill it this cycle.
        if (!stall) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
        end

        if (redirect) begin
            pc_d          = npc_in;
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
            skid_clear    = 1'b1;
            unique case (state_q)
                S_BOOT: state_d = S_REQ;
                S_REQ: begin
                    // Request to the old PC is already accepted: discard its response.
                    if (imem.imem_gnt) begin
                        state_d = S_WAIT;
                        kill_d  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        state_d = S_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end
                S_HOLD: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_BOOT: state_d = S_REQ;
                S_REQ: begin
                    if (imem.imem_gnt) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = S_REQ;
                        end else if (acc) begin
                            if_id_valid_d = 1'b1;
                            if_id_pc_d    = pc_q;
                            if_id_instr_d = imem.imem_rdata;
                            pc_d          = npc_in;
                            state_d       = S_REQ;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (acc && skid_valid) begin
                        if_id_valid_d = 1'b1;
                        if_id_pc_d    = skid_pc;
                        if_id_instr_d = skid_instr;
                        pc_d          = npc_in;
                        skid_drain    = 1'b1;
                        state_d       = S_REQ;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_BOOT;
            kill_q      <= 1'b0;
            pc_q        <= RESET_PC;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            pc_q        <= pc_d;
            if_id_valid <= if_id_valid_d;
            if_id_pc    <= if_id_pc_d;
            if_id_instr <= if_id_instr_d;
        end
    end

endmodule
